// File: rtl/mult_acc16_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate block.
package mult_acc16_pkg;
  localparam int MA_WIDTH = 16;
  localparam int MA_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_control.sv
// Sequencer for mult_acc16: IDLE/CALC/DONE FSM plus the iteration counter.
module mult_control
  import mult_acc16_pkg::*;
#(
  parameter int WIDTH = MA_WIDTH,
  parameter int CNT_W = MA_CNT_W
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  output logic             load,
  output logic             step,
  output logic             finish,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state;

  assign load   = (state == S_IDLE) && start;
  assign step   = (state == S_CALC);
  assign finish = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_CALC;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        // Always WIDTH iterations, even when the remaining multiplier bits are zero
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/mult_acc16.sv
// Sequential unsigned multiply-accumulate: result = multiplicand*multiplier + addend.
module mult_acc16
  import mult_acc16_pkg::*;
#(
  parameter int WIDTH = MA_WIDTH,
  parameter int CNT_W = MA_CNT_W
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow
);
  logic             load, step, finish;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2*WIDTH-1:0] acc;

  mult_control #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk    (clk),
    .reset_a(reset_a),
    .start  (start),
    .load   (load),
    .step   (step),
    .finish (finish),
    .busy   (busy),
    .cnt    (cnt)
  );

  // 2*WIDTH accumulator cannot wrap, so the high half is an exact overflow flag
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (load) begin
        a_reg <= multiplicand;
        b_reg <= multiplier;
        acc   <= {{WIDTH{1'b0}}, addend};
      end
      if (step) begin
        if (b_reg[0]) acc <= acc + ({{WIDTH{1'b0}}, a_reg} << cnt);
        b_reg <= b_reg >> 1;
      end
      done <= finish;
      if (finish) begin
        result   <= acc[WIDTH-1:0];
        overflow <= |acc[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule
